// File: rtl/pdp8_cycle_sequencer.sv
// Major-state sequencer for the PDP-8/e: H/F/D/E/B cycles of SUB_CYCLES phases plus memory wait clocks.
// Define PDP8_DATA_BREAK_EN to enable the data-break (B cycle, brk_req/brk_ack) channel.
module pdp8_cycle_sequencer #(
    parameter int SUB_CYCLES  = 4,
    parameter int WAIT_CYCLES = 1,
    parameter int PW          = $clog2(SUB_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,
    input  logic          single_step,
    input  logic          cont,
    input  logic          trigger,
    input  logic          int_req,
    input  logic          int_ena,
    input  logic          int_inh,
    input  logic [0:11]   instruction,
    input  logic          brk_req,
    output logic [2:0]    major,
    output logic [PW-1:0] phase,
    output logic          wait_st,
    output logic          int_in_prog,
    output logic          brk_ack
);

    typedef enum logic [2:0] {
        MAJ_H = 3'd0,
        MAJ_F = 3'd1,
        MAJ_D = 3'd2,
        MAJ_E = 3'd3,
        MAJ_B = 3'd4
    } major_t;

    localparam logic [PW-1:0] PHASE_LAST = PW'(SUB_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [3:0]    WAIT_LAST  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    major_t        major_reg, major_next;
    logic [PW-1:0] phase_reg, phase_next;
    logic          wait_st_reg, wait_st_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic          iip_reg, iip_next;

    logic brk_term, irq, f_special, is_hlt, is_6002, is_jmp_i, step_hold;
    logic advance;
    logic [3:0] bnd;

`ifdef PDP8_DATA_BREAK_EN
    assign brk_term = brk_req;
    assign brk_ack  = (major_reg == MAJ_B) && !wait_st_reg && (phase_reg == PHASE_LAST);
`else
    assign brk_term = 1'b0 & brk_req;
    assign brk_ack  = 1'b0;
`endif

    assign irq       = int_req & int_ena & ~int_inh;
    assign f_special = (instruction[0:1] == 2'b11) || (instruction[0:3] == 4'b1010);
    assign is_hlt    = ({instruction[0:3], instruction[10:11]} == 6'b111110);
    assign is_6002   = (instruction == 12'o6002);
    assign is_jmp_i  = (instruction[0:3] == 4'b1011);
    assign step_hold = single_step & ~cont;

    // Instruction-boundary priority; result is {int_in_prog, major}.
    function automatic logic [3:0] boundary(input logic h, input logic b, input logic i);
        if (h)      return {1'b0, MAJ_H};
        else if (b) return {1'b0, MAJ_B};
        else if (i) return {1'b1, MAJ_E};
        else        return {1'b0, MAJ_F};
    endfunction

    always_comb begin
        major_next    = major_reg;
        phase_next    = phase_reg;
        wait_st_next  = wait_st_reg;
        wait_cnt_next = wait_cnt_reg;
        iip_next      = iip_reg;
        advance       = 1'b0;
        bnd           = {iip_reg, major_reg};
        if (wait_st_reg) begin
            if (wait_cnt_reg == WAIT_LAST) begin
                wait_st_next  = 1'b0;
                wait_cnt_next = 4'd0;
                phase_next    = PHASE_ONE;
            end else begin
                wait_cnt_next = wait_cnt_reg + 4'd1;
            end
        end else if (phase_reg == '0) begin
            // H phase 0 and the single-step hold are the only every-clock samplers.
            if (major_reg == MAJ_H) begin
                if (brk_term)              major_next = MAJ_B;
                else if (trigger && !cont) advance    = 1'b1;
                else if (cont)             major_next = MAJ_F;
            end else if (major_reg == MAJ_B || !step_hold) begin
                advance = 1'b1;
            end
            if (advance) begin
                if (WAIT_CYCLES == 0) begin
                    phase_next = PHASE_ONE;
                end else begin
                    wait_st_next  = 1'b1;
                    wait_cnt_next = 4'd0;
                end
            end
        end else if (phase_reg != PHASE_LAST) begin
            phase_next = phase_reg + PHASE_ONE;
        end else begin
            phase_next = '0;
            case (major_reg)
                MAJ_F: begin
                    if (f_special) begin
                        if (halt || is_hlt) bnd = {1'b0, MAJ_H};
                        else                bnd = boundary(halt, brk_term, irq && !is_6002);
                    end else begin
                        bnd = {1'b0, instruction[3] ? MAJ_D : MAJ_E};
                    end
                end
                MAJ_D:   bnd = is_jmp_i ? boundary(halt, brk_term, irq) : {1'b0, MAJ_E};
                MAJ_E: begin
                    if (halt)         bnd = {1'b0, MAJ_H};
                    else if (iip_reg) bnd = {1'b0, MAJ_F};
                    else              bnd = boundary(halt, brk_term, irq);
                end
                // A finishing break serves any queued request before looking at halt.
                MAJ_B:   bnd = brk_term ? {1'b0, MAJ_B} : boundary(halt, 1'b0, irq);
                default: bnd = {1'b0, MAJ_H};
            endcase
            major_next = major_t'(bnd[2:0]);
            iip_next   = bnd[3];
        end
        if (major_next == MAJ_F) iip_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            major_reg    <= MAJ_H;
            phase_reg    <= '0;
            wait_st_reg  <= 1'b0;
            wait_cnt_reg <= 4'd0;
            iip_reg      <= 1'b0;
        end else begin
            major_reg    <= major_next;
            phase_reg    <= phase_next;
            wait_st_reg  <= wait_st_next;
            wait_cnt_reg <= wait_cnt_next;
            iip_reg      <= iip_next;
        end
    end

    assign major       = major_reg;
    assign phase       = phase_reg;
    assign wait_st     = wait_st_reg;
    assign int_in_prog = iip_reg;

endmodule

// File: tb/tb_pdp8_cycle_sequencer.sv
// Scoreboard bench for pdp8_cycle_sequencer: default, 6-phase/2-wait and zero-wait instances share stimulus.
`timescale 1ns/1ps
module tb_pdp8_cycle_sequencer;

    localparam logic [2:0] H = 3'd0, F = 3'd1, D = 3'd2, E = 3'd3, B = 3'd4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, halt, single_step, cont, trigger, int_req, int_ena, int_inh, brk_req;
    logic [0:11] instruction;

    logic [2:0] major_a, major_b, major_c;
    logic [1:0] phase_a, phase_c;
    logic [2:0] phase_b;
    logic wait_a, wait_b, wait_c, iip_a, iip_b, iip_c, ack_a, ack_b, ack_c;

    // Packed observation: {major[2:0], phase[2:0], wait_st, int_in_prog, brk_ack}
    logic [8:0] obs_a, obs_b, obs_c;
    assign obs_a = {major_a, 1'b0, phase_a, wait_a, iip_a, ack_a};
    assign obs_b = {major_b, phase_b, wait_b, iip_b, ack_b};
    assign obs_c = {major_c, 1'b0, phase_c, wait_c, iip_c, ack_c};

    logic [8:0] exp_q[$];
    logic [8:0] e;
    int errors = 0;
    int checks = 0;

    pdp8_cycle_sequencer dut_a (
        .clk(clk), .reset(reset), .halt(halt), .single_step(single_step), .cont(cont),
        .trigger(trigger), .int_req(int_req), .int_ena(int_ena), .int_inh(int_inh),
        .instruction(instruction), .brk_req(brk_req), .major(major_a), .phase(phase_a),
        .wait_st(wait_a), .int_in_prog(iip_a), .brk_ack(ack_a)
    );

    pdp8_cycle_sequencer #(.SUB_CYCLES(6), .WAIT_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .halt(halt), .single_step(single_step), .cont(cont),
        .trigger(trigger), .int_req(int_req), .int_ena(int_ena), .int_inh(int_inh),
        .instruction(instruction), .brk_req(brk_req), .major(major_b), .phase(phase_b),
        .wait_st(wait_b), .int_in_prog(iip_b), .brk_ack(ack_b)
    );

    pdp8_cycle_sequencer #(.SUB_CYCLES(4), .WAIT_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .halt(halt), .single_step(single_step), .cont(cont),
        .trigger(trigger), .int_req(int_req), .int_ena(int_ena), .int_inh(int_inh),
        .instruction(instruction), .brk_req(brk_req), .major(major_c), .phase(phase_c),
        .wait_st(wait_c), .int_in_prog(iip_c), .brk_ack(ack_c)
    );

    task automatic push(input logic [2:0] maj, input logic [2:0] ph, input logic ws,
                        input logic iip, input logic ack);
        exp_q.push_back({maj, ph, ws, iip, ack});
    endtask

    // One full cycle as seen after each clock edge: phase 0, waits, phases 1..sub-1.
    task automatic push_cycle(input logic [2:0] maj, input int sub, input int waits,
                              input logic iip, input logic ack_last);
        push(maj, 3'd0, 1'b0, iip, 1'b0);
        for (int w = 0; w < waits; w++) push(maj, 3'd0, 1'b1, iip, 1'b0);
        for (int p = 1; p < sub; p++) push(maj, 3'(p), 1'b0, iip, ack_last && (p == sub - 1));
    endtask

    task automatic do_reset();
        halt = 0; single_step = 0; cont = 0; trigger = 0;
        int_req = 0; int_ena = 0; int_inh = 0; brk_req = 0;
        instruction = 12'o7000;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        push(H, 3'd0, 0, 0, 0); push(H, 3'd0, 0, 0, 0); push(H, 3'd0, 0, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL reset_a: got %b required %b", obs_a, e); end
        e = exp_q.pop_front(); checks++;
        if (obs_b !== e) begin errors++; $display("FAIL reset_b: got %b required %b", obs_b, e); end
        e = exp_q.pop_front(); checks++;
        if (obs_c !== e) begin errors++; $display("FAIL reset_c: got %b required %b", obs_c, e); end
        // Reset landing in the middle of an F cycle.
        cont = 1;
        push(F, 3'd0, 0, 0, 0); push(F, 3'd0, 1, 0, 0); push(F, 3'd1, 0, 0, 0); push(H, 3'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL reset_mid[%0d]: got %b required %b", i, obs_a, e); end
            if (i == 0) cont = 0;
            if (i == 2) reset = 1;
            if (i == 3) reset = 0;
        end
    endtask

    task automatic test_nop();
        do_reset();
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push_cycle(F, 4, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL nop[%0d]: got %b required %b", i, obs_a, e); end
        end
    endtask

    task automatic test_no_wait();
        do_reset();
        cont = 1;
        push_cycle(F, 4, 0, 0, 0); push_cycle(F, 4, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_c !== e) begin errors++; $display("FAIL no_wait[%0d]: got %b required %b", i, obs_c, e); end
        end
    endtask

    task automatic test_defer();
        do_reset();
        instruction = 12'o1400;
        cont = 1;
        push_cycle(F, 6, 2, 0, 0); push_cycle(D, 6, 2, 0, 0); push_cycle(E, 6, 2, 0, 0);
        push(F, 3'd0, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL defer[%0d]: got %b required %b", i, obs_b, e); end
        end
    endtask

    task automatic test_interrupt();
        do_reset();
        int_req = 1; int_ena = 1;
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push_cycle(E, 4, 1, 1, 0); push(F, 3'd0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL int_entry[%0d]: got %b required %b", i, obs_a, e); end
        end
        do_reset();
        instruction = 12'o6002;
        int_req = 1; int_ena = 1;
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push_cycle(F, 4, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL int_6002[%0d]: got %b required %b", i, obs_a, e); end
        end
    endtask

    task automatic test_single_step();
        do_reset();
        single_step = 1;
        cont = 1;
        repeat (4) push(F, 3'd0, 0, 0, 0);
        push(F, 3'd0, 1, 0, 0); push(F, 3'd1, 0, 0, 0); push(F, 3'd2, 0, 0, 0); push(F, 3'd3, 0, 0, 0);
        repeat (3) push(F, 3'd0, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL single_step[%0d]: got %b required %b", i, obs_a, e); end
            cont = (i == 3);
        end
    endtask

    task automatic test_halt();
        do_reset();
        trigger = 1;
        push(H, 3'd0, 1, 0, 0); push(H, 3'd1, 0, 0, 0); push(H, 3'd2, 0, 0, 0); push(H, 3'd3, 0, 0, 0);
        push(H, 3'd0, 0, 0, 0); push(H, 3'd0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            trigger = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL trigger[%0d]: got %b required %b", i, obs_a, e); end
        end
        do_reset();
        instruction = 12'o7402;
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push(H, 3'd0, 0, 0, 0); push(H, 3'd0, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL hlt[%0d]: got %b required %b", i, obs_a, e); end
        end
    endtask

`ifdef PDP8_DATA_BREAK_EN
    task automatic test_break();
        do_reset();
        instruction = 12'o1400;
        int_req = 1; int_ena = 1;
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push_cycle(D, 4, 1, 0, 0); push_cycle(E, 4, 1, 0, 0);
        push_cycle(B, 4, 1, 0, 1); push_cycle(E, 4, 1, 1, 0); push(F, 3'd0, 0, 0, 0);
        for (int i = 0; i < 26; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL break[%0d]: got %b required %b", i, obs_a, e); end
            if (i == 10) brk_req = 1;
            if (i == 19) brk_req = 0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push(H, 3'd0, 0, 0, 0);
        push_cycle(B, 4, 1, 0, 1); push_cycle(B, 4, 1, 0, 1);
        push(H, 3'd0, 0, 0, 0); push(H, 3'd0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL back_to_back[%0d]: got %b required %b", i, obs_a, e); end
            if (i == 0) begin cont = 0; halt = 1; brk_req = 1; end
            if (i == 15) brk_req = 0;
        end
    endtask
`else
    task automatic test_no_break();
        do_reset();
        instruction = 12'o1400;
        int_req = 1; int_ena = 1; brk_req = 1;
        cont = 1;
        push_cycle(F, 4, 1, 0, 0); push_cycle(D, 4, 1, 0, 0); push_cycle(E, 4, 1, 0, 0);
        push_cycle(E, 4, 1, 1, 0); push(F, 3'd0, 0, 0, 0);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            cont = 0;
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL no_break[%0d]: got %b required %b", i, obs_a, e); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nop();
        test_no_wait();
        test_defer();
        test_interrupt();
        test_single_step();
        test_halt();
`ifdef PDP8_DATA_BREAK_EN
        test_break();
        test_back_to_back();
`else
        test_no_break();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdp8_cycle_sequencer.md
# pdp8_cycle_sequencer

Parametrised major-state sequencer for the PDP-8/e core that replaces the fixed five-clock-per-cycle sequencer. It walks the Fetch, Defer, Execute, Break and Halt major cycles, each made of a configurable number of sub-phases plus configurable memory wait states. It also adds a data-break (DMA) request/acknowledge channel. It sits between the front panel and interrupt logic on one side and the datapath/memory controller on the other, which decode `major`, `phase` and `wait_st`.

## Interface
- `SUB_CYCLES`, 4: sub-phases per major cycle (>=2); phase indices 0..SUB_CYCLES-1.
- `WAIT_CYCLES`, 1: wait clocks inserted after phase 0 (0..15).
- `PW`, $clog2(SUB_CYCLES): width of `phase`.

- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `halt` input 1: panel HALT switch level.
- `single_step` input 1: panel single-step mode.
- `cont` input 1: panel CONT pulse/level.
- `trigger` input 1: panel operation request (LA/DEP/EXAM) while halted.
- `int_req`, `int_ena`, `int_inh` input 1 each: interrupt request, enable, inhibit.
- `instruction` input [0:11]: current IR, bit 0 = MSB.
- `brk_req` input 1: data-break request, level, held until `brk_ack`.
- `major` output 3: H=0, F=1, D=2, E=3, B=4.
- `phase` output PW: current sub-phase.
- `wait_st` output 1: high during wait clocks; `phase` holds 0 while it is high.
- `int_in_prog` output 1: interrupt-entry execute cycle in progress.
- `brk_ack` output 1: one-clock pulse on the last phase of a B cycle.

## Operation
- A cycle runs: phase 0, then WAIT_CYCLES clocks with `wait_st`=1, then phases 1..SUB_CYCLES-1. The major-state decision is made on the last phase.
- **Phase-0 hold:** F, D and E stay in phase 0 while `single_step & ~cont`. B never holds.
- **End of F cycle** (IOT/OPR if instruction[0:1]==11, or JMP direct if [0:3]==1010):
  - halt, or HLT ({[0:3],[10:11]}==6'b111110) -> H.
  - Otherwise apply the boundary rule.
- **Other instructions at end of F:** [3]=1 -> D; else -> E.
- **End of D cycle:** JMP I ([0:3]==1011) -> boundary rule; else -> E.
- **End of E cycle:**
  - halt -> H.
  - `int_in_prog`=1 -> F, with no break check.
  - Otherwise apply the boundary rule.
- **Boundary rule**, in priority order:
  - halt -> H.
  - `brk_req` -> B.
  - `int_req & int_ena & ~int_inh` -> E with `int_in_prog` set. From F, this is suppressed when instruction==12'o6002.
  - Otherwise -> F.
- **End of B cycle:** `brk_ack` pulses.
  - `brk_req` still high (next request) -> B again.
  - Otherwise return to the boundary rule minus the break term, i.e. halt -> H, interrupt -> E, else F.
  - A break in progress always completes, regardless of halt.
- **H major state, sampled each clock in phase 0:**
  - `brk_req` -> B.
  - `trigger & ~cont` -> run one H cycle (phases as above), then back to H phase 0.
  - `cont` -> F.
  - Otherwise hold.
- `int_in_prog` clears on entry to F phase 0.

## Timing
- Reset: `major`=H, `phase`=0, `wait_st`=0, `int_in_prog`=0, `brk_ack`=0. Reset mid-cycle aborts immediately, with no `brk_ack`.
- Unheld cycle length = SUB_CYCLES + WAIT_CYCLES clocks. Defaults give 5 clocks.
- `major` changes on the clock after the last phase. The new cycle starts at phase 0.
- Inputs are sampled only on the decision clock, except H phase 0 and the phase-0 hold, which are sampled every clock.
- Simultaneous halt and `brk_req` at a boundary: halt wins at instruction boundaries. After a B cycle, pending breaks are served before H.
- WAIT_CYCLES=0: phase 0 is followed directly by phase 1, and `wait_st` never asserts.

## Configuration
- `PDP8_DATA_BREAK_EN` defined: B state, `brk_req` and `brk_ack` behave as above.
- Not defined:
  - `brk_req` is ignored and `brk_ack` is tied 0.
  - The B encoding is never produced.
  - Boundary rule is halt > interrupt > F.

## Test plan
- Reset, then `cont` pulse, instruction 12'o7000 (NOP), defaults -> major sequence H, F (phases 0,w,1,2,3), F…; 5 clocks per F cycle.
- TAD I (12'o1400) with SUB_CYCLES=6, WAIT_CYCLES=2 -> F (8 clocks), D (8), E (8), then F.
- `int_req=int_ena=1`, `int_inh=0` at end of NOP F cycle -> E with `int_in_prog`=1, then F with `int_in_prog`=0. The same with instruction 12'o6002 -> F, no interrupt entry.
- `brk_req` asserted during E of TAD with `int_req` also high -> B, `brk_ack` pulse on B phase 3; drop `brk_req` -> E with `int_in_prog`=1.
- `single_step`=1 -> F holds at phase 0 until a one-clock `cont`, then advances exactly one cycle and holds at the next phase 0.
- In H: `trigger`=1 -> one H cycle, then H phase 0. HLT 12'o7402 from F -> H. With macro undefined, `brk_req`=1 -> never B, `brk_ack`=0.
